// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the RV32IMF 5-stage pipeline: multi-operand forwarding, load-use
// detection and a register scoreboard for out-of-band multi-cycle writebacks.
module hazard_scoreboard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 3,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_D,
  input  logic [NUM_SRC-1:0]          rs_fp_D,
  input  logic [NUM_SRC-1:0]          rs_use_D,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_E,
  input  logic [NUM_SRC-1:0]          rs_fp_E,
  input  logic [REG_AW-1:0]           rd_E,
  input  logic [REG_AW-1:0]           rd_M,
  input  logic [REG_AW-1:0]           rd_W,
  input  logic                        rd_fp_E,
  input  logic                        rd_fp_M,
  input  logic                        rd_fp_W,
  input  logic                        wr_E,
  input  logic                        wr_M,
  input  logic                        wr_W,
  input  logic                        load_E,
  input  logic                        redirect_E,
  input  logic                        mc_issue_E,
  input  logic                        mc_busy,
  input  logic                        mc_done,
  input  logic [REG_AW-1:0]           mc_rd,
  input  logic                        mc_rd_fp,
  output logic [2*NUM_SRC-1:0]        fwd_E,
  output logic                        stall_F,
  output logic                        stall_D,
  output logic                        flush_D,
  output logic                        flush_E,
  output logic                        sb_pending,
  output logic                        sb_timeout
);

  // Scoreboard key is {file flag, index}: FP registers occupy the upper half.
  localparam int KW   = REG_AW + 1;
  localparam int NKEY = 2 ** KW;

  function automatic logic key_hit(input logic [REG_AW-1:0] a, input logic a_fp,
                                   input logic [REG_AW-1:0] b, input logic b_fp);
    return (a == b) && (a_fp == b_fp) && (a_fp || (a != '0));
  endfunction

  logic [NKEY-1:0] pending;
  logic [NKEY-1:0] clr_vec;
  logic [NKEY-1:0] set_vec;
  logic [KW-1:0]   rd_key;
  logic [KW-1:0]   done_key;
  logic [TO_W-1:0] to_cnt;
  logic            lu_hz;
  logic            sb_hz;
  logic            str_hz;
  logic            waw_hz;
  logic            any_stall;

  assign rd_key   = {rd_fp_E, rd_E};
  assign done_key = {mc_rd_fp, mc_rd};

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fwd_E = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_M && key_hit(rs_E[i*REG_AW +: REG_AW], rs_fp_E[i], rd_M, rd_fp_M))
        fwd_E[2*i +: 2] = 2'b10;
      else if (wr_W && key_hit(rs_E[i*REG_AW +: REG_AW], rs_fp_E[i], rd_W, rd_fp_W))
        fwd_E[2*i +: 2] = 2'b01;
    end
  end

  // An issue only commits when the multi-cycle unit is free and the destination is not
  // already in flight; a held issue must leave the scoreboard untouched.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (mc_done)
      clr_vec[done_key] = 1'b1;
    if (mc_issue_E && !mc_busy && !pending[rd_key] && (rd_fp_E || (rd_E != '0)))
      set_vec[rd_key] = 1'b1;
  end

  // The same-cycle mc_done is bypassed so a waiting reader is released on the writeback.
  always_comb begin
    lu_hz = 1'b0;
    sb_hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_use_D[i]) begin
        if (load_E && wr_E && key_hit(rs_D[i*REG_AW +: REG_AW], rs_fp_D[i], rd_E, rd_fp_E))
          lu_hz = 1'b1;
        if (pending[{rs_fp_D[i], rs_D[i*REG_AW +: REG_AW]}] &&
            !clr_vec[{rs_fp_D[i], rs_D[i*REG_AW +: REG_AW]}])
          sb_hz = 1'b1;
      end
    end
  end

  assign str_hz     = mc_issue_E && mc_busy;
  assign waw_hz     = mc_issue_E && pending[rd_key];
  assign any_stall  = lu_hz || sb_hz || str_hz || waw_hz;
  assign stall_F    = any_stall && !redirect_E;
  assign stall_D    = any_stall && !redirect_E;
  assign flush_D    = redirect_E;
  assign flush_E    = lu_hz || sb_hz || redirect_E;
  assign sb_pending = |pending;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      to_cnt     <= '0;
      sb_timeout <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (mc_done || (pending == '0))
        to_cnt <= '0;
      else if (to_cnt != '1)
        to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_W'(TIMEOUT - 1))
        sb_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios plus random traffic,
// compared against a register-level reference model through an expectation queue.
module tb_hazard_scoreboard_unit;

  localparam int AW      = 5;
  localparam int NS      = 3;
  localparam int TIMEOUT = 200;
  localparam int NREG    = 2 ** AW;

  typedef struct packed {
    logic [NS*AW-1:0] rs_D;
    logic [NS-1:0]    rs_fp_D;
    logic [NS-1:0]    rs_use_D;
    logic [NS*AW-1:0] rs_E;
    logic [NS-1:0]    rs_fp_E;
    logic [AW-1:0]    rd_E;
    logic [AW-1:0]    rd_M;
    logic [AW-1:0]    rd_W;
    logic             rd_fp_E;
    logic             rd_fp_M;
    logic             rd_fp_W;
    logic             wr_E;
    logic             wr_M;
    logic             wr_W;
    logic             load_E;
    logic             redirect_E;
    logic             mc_issue_E;
    logic             mc_busy;
    logic             mc_done;
    logic [AW-1:0]    mc_rd;
    logic             mc_rd_fp;
  } stim_t;

  typedef struct packed {
    logic [2*NS-1:0] fwd;
    logic            stall_F;
    logic            stall_D;
    logic            flush_D;
    logic            flush_E;
    logic            sb_pending;
    logic            sb_timeout;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t cur = '0;

  logic [2*NS-1:0] fwd_E;
  logic stall_F, stall_D, flush_D, flush_E, sb_pending, sb_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference state: one pending flag per architectural register, and how many edges the
  // scoreboard has sat non-empty without a writeback.
  bit pend_m [0:1][0:NREG-1];
  int stuck_cycles = 0;
  bit timeout_m = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(AW), .NUM_SRC(NS), .TO_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(cur.rs_D), .rs_fp_D(cur.rs_fp_D), .rs_use_D(cur.rs_use_D),
    .rs_E(cur.rs_E), .rs_fp_E(cur.rs_fp_E),
    .rd_E(cur.rd_E), .rd_M(cur.rd_M), .rd_W(cur.rd_W),
    .rd_fp_E(cur.rd_fp_E), .rd_fp_M(cur.rd_fp_M), .rd_fp_W(cur.rd_fp_W),
    .wr_E(cur.wr_E), .wr_M(cur.wr_M), .wr_W(cur.wr_W),
    .load_E(cur.load_E), .redirect_E(cur.redirect_E),
    .mc_issue_E(cur.mc_issue_E), .mc_busy(cur.mc_busy), .mc_done(cur.mc_done),
    .mc_rd(cur.mc_rd), .mc_rd_fp(cur.mc_rd_fp),
    .fwd_E(fwd_E), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .flush_E(flush_E), .sb_pending(sb_pending), .sb_timeout(sb_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Same architectural register: index and file agree, and int x0 is never a match.
  function automatic bit same_reg(input logic [AW-1:0] a, input logic af,
                                  input logic [AW-1:0] b, input logic bf);
    return (a == b) && (af == bf) && (af || a != 0);
  endfunction

  function automatic bit sb_empty();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++)
        if (pend_m[f][r]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model_outputs(input stim_t s);
    exp_t e;
    bit lu, sb, str, waw, hz;
    logic [AW-1:0] r;
    e = '0;
    lu = 0;
    sb = 0;
    for (int i = 0; i < NS; i++) begin
      r = s.rs_E[i*AW +: AW];
      if (s.wr_M && same_reg(r, s.rs_fp_E[i], s.rd_M, s.rd_fp_M))      e.fwd[2*i +: 2] = 2'b10;
      else if (s.wr_W && same_reg(r, s.rs_fp_E[i], s.rd_W, s.rd_fp_W)) e.fwd[2*i +: 2] = 2'b01;
      r = s.rs_D[i*AW +: AW];
      if (s.rs_use_D[i]) begin
        if (s.load_E && s.wr_E && same_reg(r, s.rs_fp_D[i], s.rd_E, s.rd_fp_E)) lu = 1;
        if (pend_m[s.rs_fp_D[i]][r] &&
            !(s.mc_done && s.mc_rd == r && s.mc_rd_fp == s.rs_fp_D[i])) sb = 1;
      end
    end
    str = s.mc_issue_E && s.mc_busy;
    waw = s.mc_issue_E && pend_m[s.rd_fp_E][s.rd_E];
    hz  = lu || sb || str || waw;
    e.stall_F    = hz && !s.redirect_E;
    e.stall_D    = hz && !s.redirect_E;
    e.flush_D    = s.redirect_E;
    e.flush_E    = lu || sb || s.redirect_E;
    e.sb_pending = !sb_empty();
    e.sb_timeout = timeout_m;
    return e;
  endfunction

  task automatic model_edge(input stim_t s, input logic rst_v);
    bit was_empty, issue_ok;
    if (!rst_v) begin
      for (int f = 0; f < 2; f++)
        for (int r = 0; r < NREG; r++) pend_m[f][r] = 0;
      stuck_cycles = 0;
      timeout_m = 0;
      return;
    end
    was_empty = sb_empty();
    if (stuck_cycles == TIMEOUT - 1) timeout_m = 1;
    if (s.mc_done || was_empty) stuck_cycles = 0;
    else stuck_cycles++;
    issue_ok = s.mc_issue_E && !s.mc_busy && !pend_m[s.rd_fp_E][s.rd_E];
    if (s.mc_done) pend_m[s.mc_rd_fp][s.mc_rd] = 0;
    if (issue_ok && (s.rd_fp_E || s.rd_E != 0)) pend_m[s.rd_fp_E][s.rd_E] = 1;
  endtask

  // Drive a cycle's inputs just after the edge and queue the expected response.
  task automatic apply(input stim_t s, input logic rst_v);
    cur = s;
    rst_n = rst_v;
    exp_q.push_back(model_outputs(s));
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cur, rst_n);
    #1;
  endtask

  task automatic cyc(input stim_t s, input logic rst_v);
    apply(s, rst_v);
    tick();
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int pick;
    logic [AW:0] keys[$];
    s = '0;
    for (int i = 0; i < NS; i++) begin
      s.rs_D[i*AW +: AW] = AW'($urandom_range(0, 3));
      s.rs_E[i*AW +: AW] = AW'($urandom_range(0, 3));
    end
    s.rs_fp_D    = NS'($urandom);
    s.rs_fp_E    = NS'($urandom);
    s.rs_use_D   = NS'($urandom);
    s.rd_E       = AW'($urandom_range(0, 3));
    s.rd_M       = AW'($urandom_range(0, 3));
    s.rd_W       = AW'($urandom_range(0, 3));
    s.rd_fp_E    = 1'($urandom);
    s.rd_fp_M    = 1'($urandom);
    s.rd_fp_W    = 1'($urandom);
    s.wr_E       = 1'($urandom);
    s.wr_M       = 1'($urandom);
    s.wr_W       = 1'($urandom);
    s.load_E     = ($urandom_range(0, 3) == 0);
    s.redirect_E = ($urandom_range(0, 9) == 0);
    s.mc_issue_E = ($urandom_range(0, 2) == 0);
    s.mc_busy    = ($urandom_range(0, 3) == 0);
    s.mc_done    = ($urandom_range(0, 2) == 0);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++)
        if (pend_m[f][r]) keys.push_back({1'(f), AW'(r)});
    if (keys.size() != 0 && $urandom_range(0, 4) != 0) begin
      pick = $urandom_range(0, keys.size() - 1);
      s.mc_rd_fp = keys[pick][AW];
      s.mc_rd    = keys[pick][AW-1:0];
    end else begin
      s.mc_rd_fp = 1'($urandom);
      s.mc_rd    = AW'($urandom_range(0, 3));
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("fwd_E",      32'(fwd_E),      32'(mon_e.fwd));
      check("stall_F",    32'(stall_F),    32'(mon_e.stall_F));
      check("stall_D",    32'(stall_D),    32'(mon_e.stall_D));
      check("flush_D",    32'(flush_D),    32'(mon_e.flush_D));
      check("flush_E",    32'(flush_E),    32'(mon_e.flush_E));
      check("sb_pending", 32'(sb_pending), 32'(mon_e.sb_pending));
      check("sb_timeout", 32'(sb_timeout), 32'(mon_e.sb_timeout));
    end
  end

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);
    #1;
    s = '0;
    apply(s, 1'b0);
    check("reset_stall", 32'({stall_F, stall_D, flush_D, flush_E}), 32'h0);
    check("reset_sb",    32'({sb_pending, sb_timeout}), 32'h0);
    tick();

    // Forwarding priority and file/x0 keying.
    s = '0; s.wr_M = 1; s.rd_M = 5; s.rs_E[0 +: AW] = 5;
    apply(s, 1); check("fwd_M_int", 32'(fwd_E[1:0]), 32'h2); tick();
    s.rd_fp_M = 1;
    apply(s, 1); check("fwd_file_mismatch", 32'(fwd_E[1:0]), 32'h0); tick();
    s = '0; s.wr_M = 1; s.wr_W = 1; s.rd_M = 7; s.rd_W = 7; s.rs_E[AW +: AW] = 7;
    apply(s, 1); check("fwd_M_over_W", 32'(fwd_E[3:2]), 32'h2); tick();
    s = '0; s.wr_M = 1; s.wr_W = 1;
    apply(s, 1); check("fwd_x0", 32'(fwd_E), 32'h0); tick();
    s = '0; s.wr_M = 1; s.rd_fp_M = 1; s.rs_fp_E[2] = 1;
    apply(s, 1); check("fwd_f0", 32'(fwd_E[5:4]), 32'h2); tick();

    // Load-use gated by rs_use_D.
    s = '0; s.load_E = 1; s.wr_E = 1; s.rd_E = 3; s.rs_D[AW +: AW] = 3; s.rs_use_D = 3'b010;
    apply(s, 1); check("lu_stall", 32'({stall_F, stall_D, flush_E}), 32'h7); tick();
    s.rs_use_D = 3'b000;
    apply(s, 1); check("lu_unused", 32'({stall_F, stall_D, flush_E}), 32'h0); tick();

    // fdiv f4 in flight, reader waits until the writeback cycle.
    s = '0; s.mc_issue_E = 1; s.rd_E = 4; s.rd_fp_E = 1;
    cyc(s, 1);
    s = '0; s.rs_D[0 +: AW] = 4; s.rs_fp_D[0] = 1; s.rs_use_D[0] = 1;
    apply(s, 1); check("sb_stall", 32'({stall_D, flush_E, sb_pending}), 32'h7); tick();
    cyc(s, 1);
    s.mc_done = 1; s.mc_rd = 4; s.mc_rd_fp = 1;
    apply(s, 1); check("sb_bypass", 32'({stall_D, sb_pending}), 32'h1); tick();
    s = '0;
    apply(s, 1); check("sb_drained", 32'(sb_pending), 32'h0); tick();

    // Structural and WAW holds, redirect during a hold.
    s = '0; s.mc_issue_E = 1; s.mc_busy = 1; s.rd_E = 9;
    apply(s, 1); check("str_stall", 32'({stall_F, flush_E}), 32'h2); tick();
    s = '0;
    apply(s, 1); check("str_no_set", 32'(sb_pending), 32'h0); tick();
    s.mc_issue_E = 1; s.rd_E = 9;
    cyc(s, 1);
    apply(s, 1); check("waw_stall", 32'(stall_D), 32'h1); tick();
    s.redirect_E = 1;
    apply(s, 1); check("redirect_hold", 32'({flush_D, stall_F, flush_E}), 32'h5); tick();
    s = '0; s.mc_done = 1; s.mc_rd = 9;
    cyc(s, 1);

    // Random traffic with periodic resets.
    for (int n = 0; n < 1500; n++) begin
      cyc(rand_stim(), (n % 400) != 399);
    end

    // Watchdog: a single stuck entry trips the sticky flag; reset clears it.
    s = '0;
    cyc(s, 0);
    s.mc_issue_E = 1; s.rd_E = 2;
    cyc(s, 1);
    s = '0;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      apply(s, 1);
      if (k == TIMEOUT)     check("wd_before", 32'(sb_timeout), 32'h0);
      if (k == TIMEOUT + 1) check("wd_fire",   32'(sb_timeout), 32'h1);
      tick();
    end
    s.mc_done = 1; s.mc_rd = 2;
    apply(s, 1); check("wd_sticky", 32'(sb_timeout), 32'h1); tick();
    s = '0; s.mc_issue_E = 1; s.rd_E = 6;
    cyc(s, 1);
    s = '0;
    cyc(s, 0);
    apply(s, 1); check("wd_reset", 32'({sb_timeout, sb_pending}), 32'h0); tick();

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
